// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between decode, the ALU issue stage and execute.
// The slave side is the issue stage; the master side is its environment.
interface alu_issue_stage_if #(
   parameter int XLEN   = 32,
   parameter int RFADDR = 5
);
   logic [31:0]       Instr_i;
   logic [XLEN-1:0]   PC_i;
   logic [XLEN-1:0]   RD1_i;
   logic [XLEN-1:0]   RD2_i;
   logic              valid_i;
   logic              ready_o;
   logic              flush_i;
   logic [XLEN-1:0]   ALUop1_o;
   logic [XLEN-1:0]   ALUop2_o;
   logic [3:0]        ALUctrl_o;
   logic [RFADDR-1:0] RdAddr_o;
   logic              Illegal_o;
   logic              valid_o;
   logic              ready_i;

   modport slave (
      input  Instr_i, PC_i, RD1_i, RD2_i,
      input  valid_i, flush_i, ready_i,
      output ready_o, valid_o,
      output ALUop1_o, ALUop2_o, ALUctrl_o,
      output RdAddr_o, Illegal_o
   );

   modport master (
      output Instr_i, PC_i, RD1_i, RD2_i,
      output valid_i, flush_i, ready_i,
      input  ready_o, valid_o,
      input  ALUop1_o, ALUop2_o, ALUctrl_o,
      input  RdAddr_o, Illegal_o
   );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes ALU operands/control and holds them in an
// output slot plus one skid entry so ready_o can be a plain register.
module alu_issue_stage #(
   parameter int XLEN   = 32,
   parameter int RFADDR = 5
) (
   input logic            clk_i,
   input logic            rst_ni,
   alu_issue_stage_if.slave io
);

   typedef struct packed {
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [3:0]        ctrl;
      logic [RFADDR-1:0] rd;
      logic              ill;
   } slot_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       f7_zero;
   logic       f7_alt;
   logic       is_shift;
   logic       legal;
   slot_t      dec;

   assign opc      = io.Instr_i[6:0];
   assign f3       = io.Instr_i[14:12];
   assign f7       = io.Instr_i[31:25];
   assign f7_zero  = (f7 == 7'b0000000);
   assign f7_alt   = (f7 == 7'b0100000);
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   logic unused;
   assign unused = ^io.Instr_i[19:15];

   function automatic logic [3:0] alu_fn(
      input logic [2:0] fn3,
      input logic       alt
   );
      logic [3:0] c;
      c = 4'b0000;
      case (fn3)
         3'b000: c = alt ? 4'b0001 : 4'b0000;
         3'b001: c = 4'b0010;
         3'b010: c = 4'b0100;
         3'b011: c = 4'b0110;
         3'b100: c = 4'b1000;
         3'b101: c = alt ? 4'b1011 : 4'b1010;
         3'b110: c = 4'b1100;
         3'b111: c = 4'b1110;
         default: c = 4'b0000;
      endcase
      return c;
   endfunction

   always_comb begin
      dec   = '0;
      legal = 1'b0;
      unique case (1'b1)
         (opc == OP_R): begin
            legal = f7_zero ||
                    (f7_alt && (f3 == 3'b000 || f3 == 3'b101));
            dec.op1  = io.RD1_i;
            dec.op2  = is_shift ?
                       {{(XLEN-5){1'b0}}, io.RD2_i[4:0]} :
                       io.RD2_i;
            dec.ctrl = alu_fn(f3, f7_alt);
         end
         (opc == OP_I): begin
            if (f3 == 3'b001)
               legal = f7_zero;
            else if (f3 == 3'b101)
               legal = f7_zero || f7_alt;
            else
               legal = 1'b1;
            dec.op1  = io.RD1_i;
            dec.op2  = is_shift ?
                       {{(XLEN-5){1'b0}}, io.Instr_i[24:20]} :
                       {{(XLEN-12){io.Instr_i[31]}},
                        io.Instr_i[31:20]};
            dec.ctrl = alu_fn(f3, f7_alt && (f3 == 3'b101));
         end
         (opc == OP_LUI): begin
            legal   = 1'b1;
            dec.op2 = {io.Instr_i[31:12], 12'b0};
         end
         (opc == OP_AUIPC): begin
            legal   = 1'b1;
            dec.op1 = io.PC_i;
            dec.op2 = {io.Instr_i[31:12], 12'b0};
         end
         default: legal = 1'b0;
      endcase
      // Illegal bundles still flow but carry no operands or writeback
      if (legal) begin
         dec.rd = io.Instr_i[11:7];
      end else begin
         dec     = '0;
         dec.ill = 1'b1;
      end
   end

   slot_t m_q, s_q, m_n;
   logic  m_v, s_v, rdy_q;
   logic  m_v_n, s_v_n, ld_m, ld_s;
   logic  acc, hs;

   assign acc = io.valid_i && rdy_q && !io.flush_i;
   assign hs  = m_v && io.ready_i;

   always_comb begin
      m_v_n = m_v;
      s_v_n = s_v;
      ld_m  = 1'b0;
      ld_s  = 1'b0;
      m_n   = dec;
      if (!m_v) begin
         m_v_n = acc;
         ld_m  = acc;
      end else if (hs) begin
         if (s_v) begin
            ld_m  = 1'b1;
            m_n   = s_q;
            s_v_n = acc;
            ld_s  = acc;
         end else begin
            ld_m  = acc;
            m_v_n = acc;
         end
      end else if (acc) begin
         ld_s  = 1'b1;
         s_v_n = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_q   <= '0;
         s_q   <= '0;
         m_v   <= 1'b0;
         s_v   <= 1'b0;
         rdy_q <= 1'b1;
      end else if (io.flush_i) begin
         m_v   <= 1'b0;
         s_v   <= 1'b0;
         rdy_q <= 1'b1;
      end else begin
         m_v   <= m_v_n;
         s_v   <= s_v_n;
         rdy_q <= !s_v_n;
         if (ld_m) m_q <= m_n;
         if (ld_s) s_q <= dec;
      end
   end

   assign io.ready_o   = rdy_q;
   assign io.valid_o   = m_v;
   assign io.ALUop1_o  = m_q.op1;
   assign io.ALUop2_o  = m_q.op2;
   assign io.ALUctrl_o = m_q.ctrl;
   assign io.RdAddr_o  = m_q.rd;
   assign io.Illegal_o = m_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode vector table, handshake corner
// sequences and random traffic against a queue-based reference.
module tb_alu_issue_stage;

   logic clk = 1'b0;
   logic rst_ni;
   always #5 clk = ~clk;

   alu_issue_stage_if bus ();

   alu_issue_stage dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .io     (bus.slave)
   );

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   exp_t q[$];
   vec_t tv[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t dut_out();
      exp_t o;
      o.op1  = bus.ALUop1_o;
      o.op2  = bus.ALUop2_o;
      o.ctrl = bus.ALUctrl_o;
      o.rd   = bus.RdAddr_o;
      o.ill  = bus.Illegal_o;
      return o;
   endfunction

   function automatic logic [31:0] R(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] I(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] U(input logic [19:0] imm,
      input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   // Reference decode straight from the instruction-set rules
   function automatic exp_t ref_dec(input logic [31:0] ins,
      input logic [31:0] pc, input logic [31:0] a,
      input logic [31:0] b);
      exp_t r;
      logic [31:0] tab;
      logic [6:0] opc, f7;
      logic [2:0] f3;
      bit isr, shift, alt, ok;
      tab = 32'hECA86420;
      opc = ins[6:0];
      f7  = ins[31:25];
      f3  = ins[14:12];
      r = '0;
      r.ill = 1'b1;
      if (opc == 7'h37 || opc == 7'h17) begin
         r.op1 = (opc == 7'h17) ? pc : 32'h0;
         r.op2 = {ins[31:12], 12'h000};
         r.ctrl = 4'h0;
         r.rd = ins[11:7];
         r.ill = 1'b0;
      end else if (opc == 7'h33 || opc == 7'h13) begin
         isr = (opc == 7'h33);
         shift = (f3 == 3'd1) || (f3 == 3'd5);
         alt = (f7 == 7'h20);
         ok = 1'b1;
         if (isr || shift)
            ok = (f7 == 7'h00) ||
                 (alt && (f3 == 3'd5 || (isr && f3 == 3'd0)));
         if (ok) begin
            r.op1 = a;
            if (shift)
               r.op2 = isr ? (b % 32) : 32'(ins[24:20]);
            else
               r.op2 = isr ? b : {{20{ins[31]}}, ins[31:20]};
            r.ctrl = tab[f3*4 +: 4];
            if ((isr || shift) && alt) r.ctrl[0] = 1'b1;
            r.rd = ins[11:7];
            r.ill = 1'b0;
         end
      end
      return r;
   endfunction

   // One clock: drive at edge+1, update the model at the edge,
   // then check valid/ready/slot contents at the next edge+1.
   task automatic step(input logic v, input logic r, input logic f,
      input logic [31:0] ins, input logic [31:0] pc,
      input logic [31:0] a, input logic [31:0] b);
      bit acc, hs;
      exp_t e, dropped;
      bus.valid_i = v;
      bus.ready_i = r;
      bus.flush_i = f;
      bus.Instr_i = ins;
      bus.PC_i = pc;
      bus.RD1_i = a;
      bus.RD2_i = b;
      acc = v && (q.size() < 2) && !f;
      hs = (q.size() > 0) && r;
      e = ref_dec(ins, pc, a, b);
      @(posedge clk);
      if (f) begin
         q.delete();
      end else begin
         if (hs) dropped = q.pop_front();
         if (acc) q.push_back(e);
      end
      #1;
      chk("valid_o", 80'(bus.valid_o), 80'(q.size() > 0));
      chk("ready_o", 80'(bus.ready_o), 80'(q.size() < 2));
      if (q.size() > 0) chk("slot", 80'(dut_out()), 80'(q[0]));
   endtask

   task automatic add_vec(input logic [31:0] ins,
      input logic [31:0] pc, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] op1,
      input logic [31:0] op2, input logic [3:0] ctrl,
      input logic [4:0] rd, input logic ill);
      vec_t t;
      t.ins = ins; t.pc = pc; t.a = a; t.b = b;
      t.e.op1 = op1; t.e.op2 = op2; t.e.ctrl = ctrl;
      t.e.rd = rd; t.e.ill = ill;
      tv.push_back(t);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int sel;
      w = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
         0, 1, 2: w[6:0] = 7'b0110011;
         3, 4, 5: w[6:0] = 7'b0010011;
         6:       w[6:0] = 7'b0110111;
         7:       w[6:0] = 7'b0010111;
         default: ;
      endcase
      sel = $urandom_range(0, 3);
      if (sel == 0) w[31:25] = 7'h00;
      else if (sel == 1) w[31:25] = 7'h20;
      return w;
   endfunction

   initial begin
      int k, cyc, seen;
      rst_ni = 1'b0;
      bus.valid_i = 0; bus.ready_i = 0; bus.flush_i = 0;
      bus.Instr_i = 0; bus.PC_i = 0; bus.RD1_i = 0; bus.RD2_i = 0;
      @(posedge clk);
      #1;
      chk("rst_valid", 80'(bus.valid_o), 80'(0));
      chk("rst_ready", 80'(bus.ready_o), 80'(1));
      chk("rst_data", 80'(dut_out()), 80'(0));
      rst_ni = 1'b1;

      add_vec(R(7'h00,2,1,3'd0,3), 0, 5, 32'hFFFFFFFF,
              5, 32'hFFFFFFFF, 4'h0, 3, 0);
      add_vec(R(7'h20,2,1,3'd5,4), 0, 32'h80000000, 32'h123,
              32'h80000000, 3, 4'hB, 4, 0);
      add_vec(I({7'h20,5'd31},1,3'd5,5), 0, 32'hF0, 0,
              32'hF0, 32'h1F, 4'hB, 5, 0);
      add_vec(I(12'h800,1,3'd0,6), 0, 7, 0,
              7, 32'hFFFFF800, 4'h0, 6, 0);
      add_vec(U(20'h12345,7,7'h17), 32'h1000, 9, 9,
              32'h1000, 32'h12345000, 4'h0, 7, 0);
      add_vec(U(20'hABCDE,8,7'h37), 32'h40, 32'h55, 0,
              0, 32'hABCDE000, 4'h0, 8, 0);
      add_vec(R(7'h20,2,1,3'd0,9), 0, 32'h10, 3,
              32'h10, 3, 4'h1, 9, 0);
      add_vec(R(7'h00,2,1,3'd3,10), 0, 1, 2,
              1, 2, 4'h6, 10, 0);
      add_vec(I(12'hFFF,1,3'd4,11), 0, 32'hAA, 0,
              32'hAA, 32'hFFFFFFFF, 4'h8, 11, 0);
      add_vec(R(7'h00,2,1,3'd1,12), 0, 1, 32'hFFFFFFE5,
              1, 5, 4'h2, 12, 0);
      add_vec(32'h0000067F, 0, 1, 2, 0, 0, 4'h0, 0, 1);
      add_vec(R(7'h01,2,1,3'd0,13), 0, 1, 2, 0, 0, 4'h0, 0, 1);
      add_vec(I({7'h20,5'd3},1,3'd1,14), 0, 1, 2,
              0, 0, 4'h0, 0, 1);
      add_vec(I(12'h7FF,1,3'd7,15), 0, 32'hFFFF, 0,
              32'hFFFF, 32'h7FF, 4'hE, 15, 0);
      add_vec(R(7'h20,2,1,3'd3,16), 0, 1, 2, 0, 0, 4'h0, 0, 1);
      add_vec(R(7'h00,2,1,3'd5,17), 0, 8, 32'h21,
              8, 1, 4'hA, 17, 0);
      add_vec(I(12'hFFE,1,3'd2,18), 0, 3, 0,
              3, 32'hFFFFFFFE, 4'h4, 18, 0);
      add_vec(I(12'h004,1,3'd5,19), 0, 3, 0,
              3, 4, 4'hA, 19, 0);

      foreach (tv[i]) begin
         step(1, 1, 0, tv[i].ins, tv[i].pc, tv[i].a, tv[i].b);
         chk($sformatf("vec%0d", i), 80'(dut_out()), 80'(tv[i].e));
      end
      step(0, 1, 0, 0, 0, 0, 0);

      // Backpressure: four bundles, execute stalled for the first cycles
      k = 0;
      seen = 0;
      for (cyc = 0; cyc < 16; cyc++) begin
         bit v, r, take;
         v = (k < 4);
         r = (cyc >= 3);
         take = v && (q.size() < 2);
         if (bus.valid_o && r) begin
            chk("bp_order", 80'(bus.RdAddr_o), 80'(seen + 1));
            seen++;
         end
         step(v, r, 0, I(12'(k), 1, 3'd0, 5'(k + 1)), 0, k, 0);
         if (take) k++;
         if (cyc == 1) chk("bp_ready_low", 80'(bus.ready_o), 80'(0));
      end
      chk("bp_count", 80'(seen), 80'(4));

      // Flush with both entries full and a bundle offered
      step(1, 0, 0, I(12'h1, 1, 3'd0, 5'd20), 0, 0, 0);
      step(1, 0, 0, I(12'h2, 1, 3'd0, 5'd21), 0, 0, 0);
      step(1, 0, 1, I(12'h3, 1, 3'd0, 5'd22), 0, 0, 0);
      chk("flush_valid", 80'(bus.valid_o), 80'(0));
      chk("flush_ready", 80'(bus.ready_o), 80'(1));
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a stall
      step(1, 0, 0, I(12'h5, 1, 3'd0, 5'd23), 0, 1, 0);
      step(1, 0, 0, I(12'h6, 1, 3'd0, 5'd24), 0, 1, 0);
      bus.valid_i = 0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", 80'(bus.valid_o), 80'(0));
      chk("arst_ready", 80'(bus.ready_o), 80'(1));
      chk("arst_data", 80'(dut_out()), 80'(0));
      q.delete();
      #2;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_after", 80'(bus.valid_o), 80'(0));

      // Random traffic against the queue model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
              $urandom_range(0, 19) == 0, rand_instr(),
              $urandom, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
